// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one instruction-memory read at a time and
// holds the returned word for decode, with redirect flushing and stall backpressure.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] instruction,
    output logic [63:0] inst_pc,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] pc;
    logic [63:0] redirect_target;
    logic        issue;
    logic        capture;
    logic        consume;

    // Targets are forced to word alignment; the low two bits are dropped.
    assign redirect_target = redirect_pc & ~64'h3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        capture    = 1'b0;
        consume    = inst_valid && !stall;
        imem_req   = (state != IDLE);
        case (state)
            IDLE: begin
                // Never issue while an unconsumed instruction is stalled.
                if (!redirect && (!inst_valid || !stall)) begin
                    state_next = REQ;
                    issue      = 1'b1;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    state_next = IDLE;
                    capture    = !redirect;
                end else if (redirect) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (imem_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_target;
        end else if (capture) begin
            pc <= pc + 64'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_addr <= 64'h0;
        end else if (issue) begin
            imem_addr <= pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction <= 32'h0;
            inst_pc     <= 64'h0;
        end else if (capture) begin
            instruction <= imem_rdata;
            inst_pc     <= imem_addr;
        end
    end

    // Redirect wins over a same-edge capture or consumption.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_valid <= 1'b0;
        end else if (redirect) begin
            inst_valid <= 1'b0;
        end else if (capture) begin
            inst_valid <= 1'b1;
        end else if (consume) begin
            inst_valid <= 1'b0;
        end
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, meaning the reset; reset is asynchronous and active-high.
REQ-004 SHALL have port imem_req, output, 1, meaning an instruction-memory read request is outstanding.
REQ-005 SHALL have port imem_addr, output, 64, meaning the byte address of the outstanding request.
REQ-006 SHALL have port imem_ack, input, 1, meaning a one-cycle pulse: imem_rdata is valid this cycle.
REQ-007 SHALL have port imem_rdata, input, 32, meaning the fetched instruction word.
REQ-008 SHALL have port redirect, input, 1, meaning a branch or jump is taken this cycle.
REQ-009 SHALL have port redirect_pc, input, 64, meaning the target address, sampled when redirect=1.
REQ-010 SHALL have port stall, input, 1, meaning the decode stage cannot accept an instruction this cycle.
REQ-011 SHALL have port instruction, output, 32, meaning the registered instruction word driven to the field decoder.
REQ-012 SHALL have port inst_pc, output, 64, meaning the address of the instruction on the instruction port.
REQ-013 SHALL have port inst_valid, output, 1, meaning instruction and inst_pc hold an unconsumed instruction.

Function
REQ-014 SHALL implement states IDLE, REQ and FLUSH; imem_req SHALL be 1 exactly in REQ and FLUSH.
REQ-015 SHALL treat an instruction as consumed at an edge where inst_valid=1 and stall=0; consumption SHALL clear inst_valid unless a capture occurs at the same edge.
REQ-016 IDLE, redirect=0, (inst_valid=0 or stall=0): at the edge SHALL move to REQ and load imem_addr with pc.
REQ-017 IDLE, other cases: SHALL remain in IDLE; imem_ack in IDLE SHALL be ignored.
REQ-018 REQ, imem_ack=1, redirect=0: SHALL load instruction with imem_rdata, inst_pc with imem_addr, set inst_valid=1, load pc with pc+4, and move to IDLE.
REQ-019 REQ, imem_ack=0: SHALL hold imem_req=1 and imem_addr stable.
REQ-020 REQ, redirect=1, imem_ack=1: SHALL discard imem_rdata and move to IDLE.
REQ-021 REQ, redirect=1, imem_ack=0: SHALL move to FLUSH while keeping imem_addr unchanged.
REQ-022 FLUSH: SHALL keep imem_req=1 and imem_addr unchanged until imem_ack; on imem_ack SHALL discard data and move to IDLE.
REQ-023 On redirect=1 in any state: SHALL load pc with {redirect_pc[63:2],2'b00} and clear inst_valid at that edge; redirect SHALL take priority over consumption and capture.
REQ-024 On redirect in FLUSH: SHALL update pc again without leaving FLUSH.
REQ-025 pc+4 SHALL wrap modulo 2^64 (64'hFFFF_FFFF_FFFF_FFFC -> 0).
REQ-026 SHALL never issue a request while inst_valid=1 and stall=1, so a capture never overwrites an unconsumed instruction.
REQ-027 Latency: imem_ack at edge k SHALL make inst_valid=1 after edge k; minimum spacing between successive requests is 2 cycles.

Reset
REQ-028 On reset=1, asynchronously: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, instruction=0, inst_pc=0, inst_valid=0.
REQ-029 Reset during REQ or FLUSH SHALL abandon the outstanding request; an imem_ack arriving after reset release SHALL be ignored.
REQ-030 The first request SHALL appear after the first rising edge following reset deassertion, with imem_addr=RESET_PC.

Verification
REQ-031 Reset release, RESET_PC=0x1000, imem_ack after 2 cycles with rdata=0x00500093 -> imem_addr=0x1000; instruction=0x00500093, inst_pc=0x1000, inst_valid=1; next imem_addr=0x1004.
REQ-032 inst_valid=1 with stall held high for 5 cycles -> imem_req stays 0 and instruction is unchanged; stall low -> next request is issued at the following edge.
REQ-033 redirect=1, redirect_pc=0x2002 while REQ is waiting -> FLUSH; the late ack is dropped with inst_valid=0; next imem_addr=0x2000.
REQ-034 redirect and imem_ack in the same cycle -> data dropped, inst_valid=0, next imem_addr=redirect target.
REQ-035 pc=0xFFFF_FFFF_FFFF_FFFC fetched -> next imem_addr=0x0.
REQ-036 Reset asserted mid-FLUSH, then imem_ack after release -> all outputs at reset values, ack ignored, first request to RESET_PC.
